// File: rtl/parking_meter_bank.sv
// -----------------------------------------------------------------------------
// parking_meter_bank
//
// Multi-space parking meter core. Keeps N_METERS independent seconds counters,
// adds coin credit, applies preset loads and decrements every running meter on
// an internally generated 1 Hz tick. One meter, chosen by disp_chan, is
// presented to the display path together with a blink/blank control.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   coin_valid    in   one-cycle coin strobe
//   coin_chan     in   [SW]  target meter for the coin
//   coin_code     in   [2]   0:+10 1:+180 2:+200 3:+550 seconds
//   preset_valid  in   one-cycle preset strobe
//   preset_chan   in   [SW]  target meter for the preset
//   preset_sel    in   0: load 10, 1: load 205
//   disp_chan     in   [SW]  meter shown on the display
//   disp_sec      out  [CW]  registered count of the displayed meter
//   disp_blank    out  registered; 1 blanks all digits
//   expired       out  [N_METERS] registered; bit i set when meter i is 0
//   tick_1hz      out  registered one-cycle pulse every TICK_DIV cycles
// -----------------------------------------------------------------------------
module parking_meter_bank #(
    parameter int N_METERS = 4,
    parameter int TICK_DIV = 100000000,
    parameter int MAX_SEC  = 9999,
    parameter int LOW_SEC  = 200,
    parameter int CW       = 14,
    parameter int SW       = (N_METERS > 1) ? $clog2(N_METERS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [SW-1:0]       coin_chan,
    input  logic [1:0]          coin_code,
    input  logic                preset_valid,
    input  logic [SW-1:0]       preset_chan,
    input  logic                preset_sel,
    input  logic [SW-1:0]       disp_chan,
    output logic [CW-1:0]       disp_sec,
    output logic                disp_blank,
    output logic [N_METERS-1:0] expired,
    output logic                tick_1hz
);

    localparam int PW  = $clog2(TICK_DIV);
    localparam int CW1 = CW + 1;

    // Coin credit in seconds, sized one bit wider than the counter so the
    // sum with a near-full meter cannot wrap before the clamp.
    function automatic logic [CW:0] coin_value(input logic [1:0] code);
        logic [CW:0] v;
        case (code)
            2'd0:    v = CW1'(10);
            2'd1:    v = CW1'(180);
            2'd2:    v = CW1'(200);
            default: v = CW1'(550);
        endcase
        return v;
    endfunction

    // State
    logic [PW-1:0]       r_presc;
    logic                r_tick_1hz;
    logic [CW-1:0]       r_sec [N_METERS];
    logic [CW-1:0]       r_disp_sec;
    logic                r_disp_blank;
    logic [N_METERS-1:0] r_expired;

    // Combinational
    logic                w_tick;
    logic                w_half_phase;
    logic [CW:0]         w_add [N_METERS];
    logic [CW:0]         w_sum [N_METERS];
    logic [CW-1:0]       w_sec_next [N_METERS];
    logic [CW-1:0]       w_sel_sec;
    logic                w_sel_valid;
    logic                w_blank;

    // The meters decrement on the same edge that raises tick_1hz, so the
    // internal strobe is the terminal count itself, not the registered pulse.
    assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
    assign w_half_phase = (r_presc >= PW'(TICK_DIV / 2));

    // Per-meter next value. Out-of-range channel numbers never match any
    // meter index, so such commands fall away without extra logic.
    always_comb begin
        for (int i = 0; i < N_METERS; i++) begin
            w_add[i] = (coin_valid && (coin_chan == SW'(i))) ? coin_value(coin_code) : '0;
            w_sum[i] = {1'b0, r_sec[i]} + w_add[i]
                     - CW1'(w_tick && (r_sec[i] != '0));
            if (preset_valid && (preset_chan == SW'(i))) begin
                // A preset overrides both coin and tick for this meter.
                w_sec_next[i] = preset_sel ? CW'(205) : CW'(10);
            end else if (w_sum[i] > CW1'(MAX_SEC)) begin
                w_sec_next[i] = CW'(MAX_SEC);
            end else begin
                w_sec_next[i] = w_sum[i][CW-1:0];
            end
        end
    end

    // Display selection.
    // NOTE: every variable driven here gets a default before any branch;
    // otherwise an unmatched disp_chan would hold the old value and infer a latch.
    always_comb begin
        w_sel_sec   = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < N_METERS; i++) begin
            if (disp_chan == SW'(i)) begin
                w_sel_sec   = r_sec[i];
                w_sel_valid = 1'b1;
            end
        end
    end

    // Blink rule: expired meters flash with the prescaler half phase, low
    // meters blank on odd seconds (2 s period), healthy meters never blank.
    always_comb begin
        w_blank = 1'b0;
        if (!w_sel_valid) begin
            w_blank = 1'b1;
        end else if (w_sel_sec == '0) begin
            w_blank = w_half_phase;
        end else if (w_sel_sec <= CW'(LOW_SEC)) begin
            w_blank = w_sel_sec[0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_tick_1hz   <= 1'b0;
            r_disp_sec   <= '0;
            r_disp_blank <= 1'b0;
            r_expired    <= '1;
            // NOTE: the counter array is reset as well; a power-up meter must
            // read as expired, so this storage cannot be left uninitialised.
            for (int i = 0; i < N_METERS; i++) begin
                r_sec[i] <= '0;
            end
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            r_tick_1hz <= w_tick;
            for (int i = 0; i < N_METERS; i++) begin
                r_sec[i]     <= w_sec_next[i];
                r_expired[i] <= (r_sec[i] == '0);
            end
            r_disp_sec   <= w_sel_sec;
            r_disp_blank <= w_blank;
        end
    end

    assign disp_sec   = r_disp_sec;
    assign disp_blank = r_disp_blank;
    assign expired    = r_expired;
    assign tick_1hz   = r_tick_1hz;

endmodule

// File: tb/tb_parking_meter_bank.sv
// -----------------------------------------------------------------------------
// tb_parking_meter_bank
//
// Directed bench for parking_meter_bank with TICK_DIV = 10, N_METERS = 4,
// SW = 3. A behavioural model of the meter bank produces the expected output
// set for every clock; it is queued when the stimulus is applied and popped
// and compared once the DUT has registered its outputs.
// -----------------------------------------------------------------------------
module tb_parking_meter_bank;

    localparam int N       = 4;
    localparam int TDIV    = 10;
    localparam int MAXS    = 9999;
    localparam int LOWS    = 200;
    localparam int CW      = 14;
    localparam int SW      = 3;

    typedef struct {
        logic [CW-1:0] sec;
        logic          blank;
        logic [N-1:0]  expired;
        logic          tick;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          coin_valid;
    logic [SW-1:0] coin_chan;
    logic [1:0]    coin_code;
    logic          preset_valid;
    logic [SW-1:0] preset_chan;
    logic          preset_sel;
    logic [SW-1:0] disp_chan;
    logic [CW-1:0] disp_sec;
    logic          disp_blank;
    logic [N-1:0]  expired;
    logic          tick_1hz;

    int checks   = 0;
    int failures = 0;

    // Model state
    int   m_sec [N];
    int   m_presc;
    exp_t q [$];

    parking_meter_bank #(
        .N_METERS (N),
        .TICK_DIV (TDIV),
        .MAX_SEC  (MAXS),
        .LOW_SEC  (LOWS),
        .CW       (CW),
        .SW       (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_chan    (coin_chan),
        .coin_code    (coin_code),
        .preset_valid (preset_valid),
        .preset_chan  (preset_chan),
        .preset_sel   (preset_sel),
        .disp_chan    (disp_chan),
        .disp_sec     (disp_sec),
        .disp_blank   (disp_blank),
        .expired      (expired),
        .tick_1hz     (tick_1hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int coin_secs(input logic [1:0] code);
        case (code)
            2'd0:    return 10;
            2'd1:    return 180;
            2'd2:    return 200;
            default: return 550;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_sec[i] = 0;
        m_presc = 0;
        q.delete();
    endtask

    // One clock: predict the registered outputs from the pre-edge model state,
    // advance the model, let the DUT clock, then compare.
    task automatic step();
        exp_t e;
        int   s;
        int   n;
        bit   tk;
        tk     = (m_presc == TDIV - 1);
        e.tick = tk;
        for (int i = 0; i < N; i++) e.expired[i] = (m_sec[i] == 0);
        if (int'(disp_chan) < N) begin
            s     = m_sec[disp_chan];
            e.sec = CW'(s);
            if (s == 0)         e.blank = (m_presc >= TDIV / 2);
            else if (s <= LOWS) e.blank = (s % 2 == 1);
            else                e.blank = 1'b0;
        end else begin
            e.sec   = '0;
            e.blank = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (preset_valid && int'(preset_chan) == i) begin
                m_sec[i] = preset_sel ? 205 : 10;
            end else begin
                n = m_sec[i];
                if (coin_valid && int'(coin_chan) == i) n += coin_secs(coin_code);
                if (tk && m_sec[i] != 0) n -= 1;
                m_sec[i] = (n > MAXS) ? MAXS : n;
            end
        end
        m_presc = (m_presc == TDIV - 1) ? 0 : m_presc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("disp_sec",   32'(disp_sec),   32'(e.sec));
        check("disp_blank", 32'(disp_blank), 32'(e.blank));
        check("expired",    32'(expired),    32'(e.expired));
        check("tick_1hz",   32'(tick_1hz),   32'(e.tick));
        coin_valid   = 1'b0;
        preset_valid = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next edge is a tick edge (bounded by one period).
    task automatic to_pre_tick();
        for (int i = 0; i < TDIV && m_presc != TDIV - 1; i++) step();
    endtask

    task automatic coin(input int ch, input logic [1:0] code);
        coin_valid = 1'b1;
        coin_chan  = SW'(ch);
        coin_code  = code;
    endtask

    task automatic preset(input int ch, input logic sel);
        preset_valid = 1'b1;
        preset_chan  = SW'(ch);
        preset_sel   = sel;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_sec"},   32'(disp_sec),   32'd0);
        check({tag, "_disp_blank"}, 32'(disp_blank), 32'd0);
        check({tag, "_expired"},    32'(expired),    32'hF);
        check({tag, "_tick"},       32'(tick_1hz),   32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        coin_valid   = 1'b0;
        coin_chan    = '0;
        coin_code    = '0;
        preset_valid = 1'b0;
        preset_chan  = '0;
        preset_sel   = 1'b0;
        disp_chan    = '0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle: ticks at cycles 10 and 20, expired meter flashes on half phase
        steps(25);

        // +550 on meter 2
        disp_chan = 3'd2;
        coin(2, 2'd3);
        step();
        step();
        check("coin550_disp", 32'(disp_sec), 32'd550);
        steps(35);
        check("coin550_expired2", 32'(expired[2]), 32'd0);

        // Preset on meter 1 coincident with coin on meter 1 and a tick
        to_pre_tick();
        preset(1, 1'b1);
        coin(1, 2'd0);
        step();
        disp_chan = 3'd1;
        step();
        check("preset_wins", 32'(disp_sec), 32'd205);

        // Preset on meter 1 and coin on meter 0 in the same cycle
        preset(1, 1'b1);
        coin(0, 2'd0);
        step();
        disp_chan = 3'd0;
        step();
        check("coin_other_chan", 32'(disp_sec), 32'd10);

        // Saturation on meter 3
        disp_chan = 3'd3;
        for (int i = 0; i < 40 && m_sec[3] + 550 <= 9990; i++) begin
            coin(3, 2'd3);
            step();
        end
        for (int i = 0; i < 40 && m_sec[3] + 10 <= 9990; i++) begin
            coin(3, 2'd0);
            step();
        end
        coin(3, 2'd3);
        step();
        step();
        check("sat_clamp", 32'(disp_sec), 32'd9999);
        to_pre_tick();
        coin(3, 2'd0);
        step();
        step();
        check("sat_coin_tick", 32'(disp_sec), 32'd9999);
        to_pre_tick();
        step();
        step();
        check("sat_tick_alone", 32'(disp_sec), 32'd9998);

        // Meter 0 preset to 10 and run through expiry
        preset(0, 1'b0);
        disp_chan = 3'd0;
        steps(140);
        check("expiry_expired0", 32'(expired[0]), 32'd1);
        check("expiry_disp", 32'(disp_sec), 32'd0);

        // Out-of-range channels
        coin(5, 2'd3);
        step();
        preset(6, 1'b1);
        step();
        disp_chan = 3'd5;
        step();
        step();
        check("bad_disp_sec", 32'(disp_sec), 32'd0);
        check("bad_disp_blank", 32'(disp_blank), 32'd1);
        disp_chan = 3'd2;
        steps(3);

        // Mid-run reset with a pending coin
        rst_n = 1'b0;
        coin(2, 2'd3);
        #1;
        check_reset_outputs("midreset_async");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        rst_n      = 1'b1;
        coin_valid = 1'b0;
        steps(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_meter_bank.md
# parking_meter_bank

Parametrised multi-space parking meter core. Holds N independent seconds counters, adds coin credits, applies preset commands and decrements every meter on an internally generated 1 Hz tick. Presents one selected meter's count and blink control to the display path (BCD converter, seven-segment mux, anode mask). Replaces the single-meter counter and its external clock divider in the top-level meter design.

## Interface
Parameters:
- N_METERS, 4, number of independent meters (1..16)
- TICK_DIV, 100000000, clk cycles per second tick (≥4, even)
- MAX_SEC, 9999, saturation ceiling for every meter
- LOW_SEC, 200, low-time blink threshold (< MAX_SEC)
- CW, 14, counter width; must satisfy 2^CW > MAX_SEC + 550
- SW, $clog2(N_METERS) (min 1), channel select width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- coin_valid  in  1  one-cycle coin strobe (already debounced/edge-detected upstream)
- coin_chan  in  SW  target meter for coin
- coin_code  in  2  0:+10, 1:+180, 2:+200, 3:+550 seconds
- preset_valid  in  1  one-cycle preset strobe
- preset_chan  in  SW  target meter for preset
- preset_sel  in  1  0: load 10, 1: load 205
- disp_chan  in  SW  meter shown on display
- disp_sec  out  CW  registered count of disp_chan
- disp_blank  out  1  registered; 1 = blank all digits this cycle
- expired  out  N_METERS  registered; bit i = 1 when meter i is 0
- tick_1hz  out  1  registered one-cycle pulse, once per TICK_DIV cycles

## Operation
- Prescaler: counts 0..TICK_DIV-1, wraps to 0. tick_1hz = 1 in the cycle after prescaler == TICK_DIV-1. half_phase = (prescaler ≥ TICK_DIV/2).
- Per meter i, each clk edge, with tick = internal tick strobe:
  - preset hit (preset_valid, preset_chan == i): sec[i] ← 10 or 205. Coin and tick for meter i ignored that cycle.
  - else: dec = tick & (sec[i] ≠ 0); add = coin value if coin hit, else 0; sec[i] ← min(sec[i] + add − dec, MAX_SEC), computed in CW+1 bits.
- Counters never go below 0; a meter at 0 stays at 0 on tick.
- Coin and preset on different channels in the same cycle both apply.
- Channel index ≥ N_METERS on coin_chan/preset_chan: command dropped, no state change. disp_chan ≥ N_METERS: disp_sec = 0, disp_blank = 1.
- Blink rule for displayed meter (s = sec[disp_chan]):
  - s == 0: disp_blank = half_phase (flash at 1 Hz, 50% duty).
  - 0 < s ≤ LOW_SEC: disp_blank = s[0] (odd seconds blank, even shown → 2 s period).
  - s > LOW_SEC: disp_blank = 0.
- expired[i] = (sec[i] == 0).

## Timing
- Reset (rst_n low, asynchronous): all sec = 0, prescaler = 0, tick_1hz = 0, disp_sec = 0, disp_blank = 0, expired = all ones.
- First tick_1hz pulse TICK_DIV cycles after rst_n deasserts; period exactly TICK_DIV thereafter.
- Coin/preset sampled at edge k → sec updated at edge k; expired, disp_sec and disp_blank reflect it at edge k+1 (1-cycle output latency).
- disp_chan change at edge k → new channel on disp_sec/disp_blank at edge k+1.
- Internal tick and tick_1hz align: meters decrement in the same cycle tick_1hz goes high.
- Reset mid-operation clears all meters and restarts prescaler; no pending command survives.
- Saturation: any sum > MAX_SEC clamps to MAX_SEC; tick on a saturated meter yields MAX_SEC−1 unless a coin also arrives that cycle.

## Test plan
Sim with TICK_DIV = 10, N_METERS = 4, defaults otherwise.
- Reset release, idle 25 cycles -> all expired = 1, disp_sec = 0, tick_1hz high at cycles 10 and 20, disp_blank = 1 for prescaler 5..9.
- coin_code 3 on ch 2 -> disp_sec(ch 2) = 550 next cycle; after 3 ticks = 547; expired[2] = 0.
- Preset sel 1 on ch 1 with simultaneous coin +10 on ch 1 and tick -> sec[1] = 205 (coin, tick dropped); coin on ch 0 same cycle -> sec[0] = 10.
- Ch 3 at 9990, coin +550 -> 9999; coin +10 coincident with tick -> 9999; next tick alone -> 9998.
- Ch 0 preset 10, observe to expiry -> disp_blank follows s[0] (9 blank, 8 shown …), reaches 0 after 10 ticks, then blinks with half_phase, stays 0 on further ticks.
- Coin with coin_chan = 5 (N_METERS = 4, SW = 3) -> no meter changes; disp_chan = 5 -> disp_sec = 0, disp_blank = 1; rst_n pulse mid-count -> all outputs return to reset values immediately.
